// File: rtl/adc_dc_offset_canceller.sv
// Per-lane DC offset estimation (block averaging) and removal on the parallel ADC bus.
// A shared control FSM sequences the lanes; each lane owns its accumulator, estimate and correction pipe.

module adc_dc_lane #(
   parameter int LOG2_AVG = 12
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] sample,
   input  logic        acc_en,
   input  logic        acc_clr,
   input  logic        commit,
   output logic [15:0] corrected,
   output logic [15:0] offset
);
   localparam int AW = 16 + LOG2_AVG;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum;
   logic signed [16:0]   diff;

   // Wide enough for 2^LOG2_AVG full-scale samples, so the sum never wraps.
   assign sum = acc + {{LOG2_AVG{sample[15]}}, sample};

   always_ff @(posedge clock) begin
      if (reset) begin
         acc       <= '0;
         offset    <= '0;
         diff      <= '0;
         corrected <= '0;
      end else begin
         diff <= {sample[15], sample} - {offset[15], offset};
         // Out of 16-bit range exactly when the two top bits of the 17-bit difference disagree.
         corrected <= (diff[16] != diff[15]) ? {diff[16], {15{~diff[16]}}} : diff[15:0];
         if (commit) begin
            // Dropping the low LOG2_AVG bits of a two's-complement sum is a floor divide.
            offset <= sum[LOG2_AVG +: 16];
            acc    <= '0;
         end else if (acc_clr) begin
            acc <= '0;
         end else if (acc_en) begin
            acc <= sum;
         end
      end
   end
endmodule

module adc_dc_offset_canceller #(
   parameter int NUMBER_OF_LINE = 8,
   parameter int LOG2_AVG       = 12
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [NUMBER_OF_LINE-1:0][15:0]      adc_data,
   input  logic                                 enable,
   input  logic                                 freeze,
   output logic [NUMBER_OF_LINE-1:0][15:0]      adc_data_out,
   output logic [NUMBER_OF_LINE-1:0][15:0]      dc_offset,
   output logic                                 offset_update
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   logic [1:0]          state;
   logic [LOG2_AVG-1:0] cnt;
   logic                acc_run;
   logic                last;
   logic                acc_en;
   logic                acc_clr;
   logic                commit;

   always_comb begin
      acc_run = (state == ST_ACCUM) && enable && !freeze;
      last    = (cnt == '1);
      commit  = acc_run && last;
      acc_en  = acc_run && !last;
      // Abort (enable low) wins over freeze; outside ACCUM the sums stay at zero.
      acc_clr = (state != ST_ACCUM) || !enable;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (enable && !freeze) state <= ST_ACCUM;
            end
            ST_ACCUM: begin
               if (!enable) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else if (!freeze) begin
                  if (last) begin
                     cnt   <= '0;
                     state <= ST_UPDATE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_UPDATE: begin
               cnt   <= '0;
               state <= (enable && !freeze) ? ST_ACCUM : ST_IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign offset_update = (state == ST_UPDATE);

   for (genvar i = 0; i < NUMBER_OF_LINE; i++) begin : g_lane
      adc_dc_lane #(.LOG2_AVG(LOG2_AVG)) u_lane (
         .clock     (clock),
         .reset     (reset),
         .sample    (adc_data[i]),
         .acc_en    (acc_en),
         .acc_clr   (acc_clr),
         .commit    (commit),
         .corrected (adc_data_out[i]),
         .offset    (dc_offset[i])
      );
   end
endmodule

// File: tb/tb_adc_dc_offset_canceller.sv
// Randomized scoreboard bench: a cycle-level behavioural model queues the expected
// outputs for every clock edge; a monitor pops and compares after each edge.

module tb_adc_dc_offset_canceller;
   localparam int N   = 8;
   localparam int L   = 4;
   localparam int BLK = 1 << L;

   logic                clk;
   logic                reset;
   logic [N-1:0][15:0]  adc_data;
   logic                enable;
   logic                freeze;
   logic [N-1:0][15:0]  adc_data_out;
   logic [N-1:0][15:0]  dc_offset;
   logic                offset_update;

   adc_dc_offset_canceller #(.NUMBER_OF_LINE(N), .LOG2_AVG(L)) dut (
      .clock         (clk),
      .reset         (reset),
      .adc_data      (adc_data),
      .enable        (enable),
      .freeze        (freeze),
      .adc_data_out  (adc_data_out),
      .dc_offset     (dc_offset),
      .offset_update (offset_update)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int out [N];
      int off [N];
      bit upd;
      int edge_no;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Behavioural model: samples collected in the current block, the estimate,
   // and the two-deep correction pipe.
   int    smp   [N];
   int    m_s1  [N];
   int    m_out [N];
   int    m_off [N];
   longint m_sum [N];
   int    m_n;
   int    m_phase;              // 0 waiting, 1 collecting, 2 announcing new estimate
   int    edge_cnt = 0;

   int    first_upd = -1;
   int    prev_upd = -1;
   int    last_upd = -1;
   int    upd_seen = 0;

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int floor_div(input longint s);
      longint d;
      d = s / BLK;
      if ((s % BLK) != 0 && s < 0) d = d - 1;
      return int'(d);
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic clear_block();
      for (int i = 0; i < N; i++) m_sum[i] = 0;
      m_n = 0;
   endtask

   // Apply one cycle of inputs and predict the outputs after the next edge.
   task automatic step(input logic r, input logic en, input logic fz);
      exp_t e;
      @(negedge clk);
      reset  = r;
      enable = en;
      freeze = fz;
      for (int i = 0; i < N; i++) adc_data[i] = 16'(smp[i]);
      if (r) begin
         for (int i = 0; i < N; i++) begin
            m_s1[i] = 0; m_out[i] = 0; m_off[i] = 0;
         end
         clear_block();
         m_phase = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            m_out[i] = sat16(m_s1[i]);
            m_s1[i]  = smp[i] - m_off[i];
         end
         if (m_phase == 0) begin
            if (en && !fz) m_phase = 1;
         end else if (m_phase == 1) begin
            if (!en) begin
               clear_block();
               m_phase = 0;
            end else if (!fz) begin
               for (int i = 0; i < N; i++) m_sum[i] += smp[i];
               m_n++;
               if (m_n == BLK) begin
                  for (int i = 0; i < N; i++) m_off[i] = floor_div(m_sum[i]);
                  clear_block();
                  m_phase = 2;
               end
            end
         end else begin
            m_phase = (en && !fz) ? 1 : 0;
         end
      end
      edge_cnt++;
      for (int i = 0; i < N; i++) begin
         e.out[i] = m_out[i];
         e.off[i] = m_off[i];
      end
      e.upd     = (m_phase == 2);
      e.edge_no = edge_cnt;
      q.push_back(e);
   endtask

   // Let the monitor consume the last queued edge without adding an unmodelled edge.
   task automatic drain();
      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < N; i++) smp[i] = v;
   endtask

   task automatic rand_smp();
      for (int i = 0; i < N; i++) smp[i] = int'($urandom_range(65535)) - 32768;
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         for (int i = 0; i < N; i++) begin
            chk($sformatf("out[%0d]@%0d", i, e.edge_no), int'($signed(adc_data_out[i])), e.out[i]);
            chk($sformatf("off[%0d]@%0d", i, e.edge_no), int'($signed(dc_offset[i])), e.off[i]);
         end
         chk($sformatf("upd@%0d", e.edge_no), int'(offset_update), int'(e.upd));
         if (offset_update === 1'b1) begin
            upd_seen++;
            if (first_upd < 0) first_upd = e.edge_no;
            prev_upd = last_upd;
            last_upd = e.edge_no;
         end
      end
   end

   initial begin
      int en_edge;
      int cnt0;
      int keep0;
      reset = 1'b1; enable = 1'b0; freeze = 1'b0; adc_data = '0;
      for (int i = 0; i < N; i++) begin
         m_s1[i] = 0; m_out[i] = 0; m_off[i] = 0; m_sum[i] = 0;
      end
      m_n = 0; m_phase = 0;

      // Reset, then plain pass-through with a zero estimate.
      repeat (3) begin rand_smp(); step(1, 0, 0); end
      drain();
      chk("reset_out", int'($signed(adc_data_out[2])), 0);
      chk("reset_upd", int'(offset_update), 0);
      repeat (6) begin rand_smp(); step(0, 0, 0); end

      // Constant +100: first estimate, then periodic pulses.
      fill(100);
      step(0, 0, 0);
      first_upd = -1;
      step(0, 1, 0);
      en_edge = edge_cnt;
      repeat (40) step(0, 1, 0);
      drain();
      // Sampling edge of enable is the first of the 17 edges counted.
      chk("first_pulse_gap", first_upd - en_edge, 16);
      chk("pulse_period", last_upd - prev_upd, 17);
      chk("const_offset", int'($signed(dc_offset[3])), 100);
      chk("const_out", int'($signed(adc_data_out[5])), 0);

      // Floor rounding on alternating lanes.
      for (int k = 0; k < 50; k++) begin
         rand_smp();
         smp[0] = (k % 2) ? 4 : 3;
         smp[1] = (k % 2) ? -4 : -3;
         step(0, 1, 0);
      end
      drain();
      chk("floor_pos", int'($signed(dc_offset[0])), 3);
      chk("floor_neg", int'($signed(dc_offset[1])), -4);

      // Saturation at both rails.
      fill(100);
      repeat (40) step(0, 1, 0);
      step(0, 0, 0);
      fill(-32768);
      repeat (4) step(0, 0, 0);
      drain();
      chk("sat_neg", int'($signed(adc_data_out[0])), -32768);
      fill(-100);
      repeat (40) step(0, 1, 0);
      step(0, 0, 0);
      fill(32767);
      repeat (4) step(0, 0, 0);
      drain();
      chk("sat_pos", int'($signed(adc_data_out[7])), 32767);

      // Freeze mid-block delays the pulse by 5; freeze over the final sample holds it off.
      first_upd = -1;
      rand_smp(); step(0, 1, 0);
      en_edge = edge_cnt;
      repeat (6) begin rand_smp(); step(0, 1, 0); end
      repeat (5) begin rand_smp(); step(0, 1, 1); end
      repeat (10) begin rand_smp(); step(0, 1, 0); end
      repeat (16) begin rand_smp(); step(0, 1, 0); end
      drain();
      chk("freeze_pulse_gap", first_upd - en_edge, 21);
      cnt0 = upd_seen;
      repeat (8) begin rand_smp(); step(0, 1, 1); end
      drain();
      chk("freeze_no_pulse", upd_seen - cnt0, 0);
      rand_smp(); step(0, 1, 0);
      drain();
      chk("freeze_release_pulse", int'(offset_update), 1);

      // Abort after 8 samples keeps the old estimate; next block is clean.
      fill(-777);
      step(0, 0, 0);
      keep0 = m_off[0];
      step(0, 1, 0);
      repeat (8) step(0, 1, 0);
      repeat (4) step(0, 0, 0);
      drain();
      chk("abort_keep", int'($signed(dc_offset[0])), keep0);
      fill(50);
      repeat (40) step(0, 1, 0);
      drain();
      chk("abort_next_est", int'($signed(dc_offset[6])), 50);

      // Random soak with occasional freeze, abort and reset.
      for (int k = 0; k < 600; k++) begin
         rand_smp();
         if ($urandom_range(3) == 0) for (int i = 0; i < N; i++) smp[i] = int'($urandom_range(600)) - 300;
         step(($urandom_range(199) == 0), ($urandom_range(19) != 0), ($urandom_range(9) == 0));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
